// File: rtl/ctrl_types_pkg.sv
// Shared control-path types: the cache operation codes carried in the OBI address MSBs.
package ctrl_types_pkg;

  typedef enum logic [2:0] {
    NOOP   = 3'd0,
    READ   = 3'd1,
    UPSERT = 3'd2,
    DELETE = 3'd3
  } operation_e;

endpackage

// File: rtl/init_types_pkg.sv
// Types and helpers for cache_obi_initiator: FSM states, op-field placement, write-enable rule.
package init_types_pkg;

  import ctrl_types_pkg::*;

  typedef enum logic [1:0] {
    INIT_IDLE,
    INIT_REQ,
    INIT_WAIT,
    INIT_RESP
  } init_state_e;

  localparam int unsigned OP_CODE_BITS         = $bits(operation_e);
  localparam int unsigned DEFAULT_ARCHITECTURE = 64;
  localparam int unsigned DEFAULT_OP_BITS      = 3;

  // The op field occupies addr[arch-1 -: op_bits]; the key fills the rest.
  function automatic int unsigned op_field_lsb(input int unsigned arch, input int unsigned op_bits);
    return arch - op_bits;
  endfunction

  function automatic logic op_writes(input operation_e op);
    return op != READ;
  endfunction

  function automatic logic op_carries_data(input operation_e op);
    return op == UPSERT;
  endfunction

endpackage

// File: rtl/cache_obi_initiator_if.sv
// Command/response handshake plus OBI request/response bundle for cache_obi_initiator.
interface cache_obi_initiator_if #(
  parameter int unsigned ARCHITECTURE = 64,
  parameter int unsigned OP_BITS      = 3
);

  logic                           cmd_valid;
  logic                           cmd_ready;
  logic [OP_BITS-1:0]             cmd_op;
  logic [ARCHITECTURE-OP_BITS-1:0] cmd_key;
  logic [2*ARCHITECTURE-1:0]      cmd_value;

  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [2*ARCHITECTURE-1:0]      rsp_value;
  logic                           rsp_succ;
  logic                           rsp_timeout;

  logic                           obi_req;
  logic [ARCHITECTURE-1:0]        obi_addr;
  logic                           obi_we;
  logic [2*ARCHITECTURE-1:0]      obi_wdata;
  logic                           obi_gnt;
  logic                           obi_rvalid;
  logic [2*ARCHITECTURE-1:0]      obi_rdata;
  logic                           obi_err;
  logic                           obi_rready;

  modport master (
    input  cmd_valid, cmd_op, cmd_key, cmd_value,
    output cmd_ready,
    output rsp_valid, rsp_value, rsp_succ, rsp_timeout,
    input  rsp_ready,
    output obi_req, obi_addr, obi_we, obi_wdata, obi_rready,
    input  obi_gnt, obi_rvalid, obi_rdata, obi_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_key, cmd_value,
    input  cmd_ready,
    input  rsp_valid, rsp_value, rsp_succ, rsp_timeout,
    output rsp_ready,
    input  obi_req, obi_addr, obi_we, obi_wdata, obi_rready,
    output obi_gnt, obi_rvalid, obi_rdata, obi_err
  );

endinterface

// File: rtl/cache_init_timeout.sv
// Response-wait counter: cleared on entry to the wait phase, flags expiry at LIMIT-1.
module cache_init_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (en && !expired) begin
      count_q <= count_q + W'(1);
    end
  end

  assign expired = (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/cache_obi_initiator.sv
// OBI initiator issuing one key-value cache operation at a time.
// Optional response timeout enabled by defining CACHE_INIT_TIMEOUT_EN.
module cache_obi_initiator
  import ctrl_types_pkg::*;
  import init_types_pkg::*;
#(
  parameter int unsigned ARCHITECTURE   = DEFAULT_ARCHITECTURE,
  parameter int unsigned OP_BITS        = DEFAULT_OP_BITS,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                    clk,
  input logic                    rst,
  cache_obi_initiator_if.master  bus
);

  localparam int unsigned VAL_BITS = 2 * ARCHITECTURE;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout_cfg
    $error("cache_obi_initiator: TIMEOUT_CYCLES must be at least 1");
  end

  init_state_e           state_q;
  logic                  cmd_ready_q;
  logic                  rsp_valid_q;
  logic [VAL_BITS-1:0]   rsp_value_q;
  logic                  rsp_succ_q;
  logic                  rsp_timeout_q;
  logic                  obi_req_q;
  logic [ARCHITECTURE-1:0] obi_addr_q;
  logic                  obi_we_q;
  logic [VAL_BITS-1:0]   obi_wdata_q;
  logic                  obi_rready_q;
  logic                  timeout_expired;
  operation_e            cmd_op_e;

  assign cmd_op_e = operation_e'(OP_CODE_BITS'(bus.cmd_op));

`ifdef CACHE_INIT_TIMEOUT_EN
  cache_init_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state_q == INIT_REQ) && bus.obi_gnt),
    .en      ((state_q == INIT_WAIT) && !bus.obi_rvalid),
    .expired (timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= INIT_IDLE;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_value_q   <= '0;
      rsp_succ_q    <= 1'b0;
      rsp_timeout_q <= 1'b0;
      obi_req_q     <= 1'b0;
      obi_addr_q    <= '0;
      obi_we_q      <= 1'b0;
      obi_wdata_q   <= '0;
      obi_rready_q  <= 1'b0;
    end else begin
      unique case (state_q)
        INIT_IDLE: begin
          if (bus.cmd_valid) begin
            cmd_ready_q <= 1'b0;
            if (cmd_op_e == NOOP) begin
              state_q       <= INIT_RESP;
              rsp_valid_q   <= 1'b1;
              rsp_value_q   <= '0;
              rsp_succ_q    <= 1'b1;
              rsp_timeout_q <= 1'b0;
            end else begin
              // Request fields are latched here so they stay stable across grant stalls.
              state_q     <= INIT_REQ;
              obi_req_q   <= 1'b1;
              obi_addr_q  <= {bus.cmd_op, bus.cmd_key};
              obi_we_q    <= op_writes(cmd_op_e);
              obi_wdata_q <= op_carries_data(cmd_op_e) ? bus.cmd_value : '0;
            end
          end
        end
        INIT_REQ: begin
          if (bus.obi_gnt) begin
            state_q      <= INIT_WAIT;
            obi_req_q    <= 1'b0;
            obi_addr_q   <= '0;
            obi_we_q     <= 1'b0;
            obi_wdata_q  <= '0;
            obi_rready_q <= 1'b1;
          end
        end
        INIT_WAIT: begin
          if (bus.obi_rvalid) begin
            state_q       <= INIT_RESP;
            obi_rready_q  <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_value_q   <= bus.obi_rdata;
            rsp_succ_q    <= !bus.obi_err;
            rsp_timeout_q <= 1'b0;
          end else if (timeout_expired) begin
            state_q       <= INIT_RESP;
            obi_rready_q  <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_value_q   <= '0;
            rsp_succ_q    <= 1'b0;
            rsp_timeout_q <= 1'b1;
          end
        end
        INIT_RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= INIT_IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= INIT_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_value   = rsp_value_q;
  assign bus.rsp_succ    = rsp_succ_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.obi_req     = obi_req_q;
  assign bus.obi_addr    = obi_addr_q;
  assign bus.obi_we      = obi_we_q;
  assign bus.obi_wdata   = obi_wdata_q;
  assign bus.obi_rready  = obi_rready_q;

endmodule

// File: tb/tb_cache_obi_initiator.sv
// Self-checking bench for cache_obi_initiator against a key-value cache slave model.
module tb_cache_obi_initiator;
  import ctrl_types_pkg::*;

  localparam int unsigned ARCH = 64;
  localparam int unsigned OPB  = 3;
  localparam int unsigned KEYB = ARCH - OPB;
  localparam int unsigned VALB = 2 * ARCH;
`ifdef CACHE_INIT_TIMEOUT_EN
  localparam int unsigned TO_CYC = 8;
`else
  localparam int unsigned TO_CYC = 255;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [VALB-1:0] store [logic [KEYB-1:0]];

  cache_obi_initiator_if #(.ARCHITECTURE(ARCH), .OP_BITS(OPB)) bus ();

  cache_obi_initiator #(
    .ARCHITECTURE   (ARCH),
    .OP_BITS        (OPB),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [VALB-1:0] rnd_val();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [KEYB-1:0] rnd_key();
    return KEYB'({$urandom, $urandom});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = '0;
    bus.cmd_key    = '0;
    bus.cmd_value  = '0;
    bus.rsp_ready  = 1'b0;
    bus.obi_gnt    = 1'b0;
    bus.obi_rvalid = 1'b0;
    bus.obi_rdata  = '0;
    bus.obi_err    = 1'b0;
  endtask

  // Cache slave behaviour: what the OBI target answers for each operation.
  task automatic cache_answer(input operation_e op, input logic [KEYB-1:0] key,
                              input logic [VALB-1:0] value,
                              output logic err, output logic [VALB-1:0] rdata);
    err   = 1'b0;
    rdata = rnd_val();
    case (op)
      READ: begin
        if (store.exists(key)) rdata = store[key];
        else begin rdata = '0; err = 1'b1; end
      end
      UPSERT: store[key] = value;
      DELETE: begin
        if (store.exists(key)) store.delete(key);
        else err = 1'b1;
      end
      default: rdata = '0;
    endcase
  endtask

  // Drives one command through the DUT acting as requester and OBI target; returns observations.
  task automatic run_txn(
    input  operation_e op, input logic [KEYB-1:0] key, input logic [VALB-1:0] value,
    input  int unsigned gnt_dly, input int unsigned rsp_dly,
    input  logic err, input logic [VALB-1:0] rdata,
    input  int unsigned bp, input bit spur,
    output logic req_seen, output logic [ARCH-1:0] addr_s, output logic we_s,
    output logic [VALB-1:0] wdata_s, output bit proto_ok, output int unsigned lat,
    output bit got_rsp, output logic [VALB-1:0] val_s, output logic succ_s,
    output logic to_s, output bit held, output bit back_idle);
    int unsigned n;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_key   = key;
    bus.cmd_value = value;
    tick();
    lat = 1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OPB'($urandom);
    bus.cmd_key   = rnd_key();
    bus.cmd_value = rnd_val();
    req_seen = bus.obi_req;
    addr_s   = bus.obi_addr;
    we_s     = bus.obi_we;
    wdata_s  = bus.obi_wdata;
    proto_ok = (bus.cmd_ready === 1'b0);
    if (req_seen === 1'b1) begin
      for (int i = 0; i < int'(gnt_dly); i++) begin
        tick();
        lat++;
        if (bus.obi_req !== 1'b1 || bus.obi_addr !== addr_s || bus.obi_we !== we_s ||
            bus.obi_wdata !== wdata_s || bus.cmd_ready !== 1'b0) proto_ok = 1'b0;
      end
      bus.obi_gnt    = 1'b1;
      bus.obi_rvalid = 1'b1;
      bus.obi_rdata  = ~rdata;
      bus.obi_err    = ~err;
      tick();
      lat++;
      bus.obi_gnt    = 1'b0;
      bus.obi_rvalid = 1'b0;
      if (bus.obi_req !== 1'b0 || bus.obi_rready !== 1'b1) proto_ok = 1'b0;
      for (int i = 0; i < int'(rsp_dly); i++) begin
        if (bus.rsp_valid === 1'b1) break;
        tick();
        lat++;
      end
      if (bus.rsp_valid !== 1'b1) begin
        bus.obi_rvalid = 1'b1;
        bus.obi_rdata  = rdata;
        bus.obi_err    = err;
        tick();
        lat++;
        bus.obi_rvalid = 1'b0;
      end
    end
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 64) begin
      tick();
      lat++;
      n++;
    end
    got_rsp = (bus.rsp_valid === 1'b1);
    val_s   = bus.rsp_value;
    succ_s  = bus.rsp_succ;
    to_s    = bus.rsp_timeout;
    if (bus.obi_rready !== 1'b0 || bus.obi_req !== 1'b0) proto_ok = 1'b0;
    held = 1'b1;
    for (int i = 0; i < int'(bp); i++) begin
      if (spur) begin
        bus.obi_rvalid = 1'b1;
        bus.obi_rdata  = rnd_val();
        bus.obi_err    = 1'($urandom);
      end
      tick();
      bus.obi_rvalid = 1'b0;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_value !== val_s || bus.rsp_succ !== succ_s ||
          bus.rsp_timeout !== to_s || bus.cmd_ready !== 1'b0 || bus.obi_req !== 1'b0) held = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    back_idle = (bus.rsp_valid === 1'b0 && bus.cmd_ready === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    n_tests++; if (bus.obi_req !== 1'b0) begin n_fail++; $display("FAIL reset_obi_req: got %b expected 0", bus.obi_req); end
    n_tests++; if (bus.obi_rready !== 1'b0) begin n_fail++; $display("FAIL reset_obi_rready: got %b expected 0", bus.obi_rready); end
    n_tests++; if ({bus.obi_we, bus.rsp_succ, bus.rsp_timeout} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.obi_we, bus.rsp_succ, bus.rsp_timeout}); end
    n_tests++; if (bus.obi_addr !== '0) begin n_fail++; $display("FAIL reset_obi_addr: got %h expected 0", bus.obi_addr); end
    n_tests++; if (bus.obi_wdata !== '0 || bus.rsp_value !== '0) begin n_fail++; $display("FAIL reset_data: got wdata %h value %h expected 0", bus.obi_wdata, bus.rsp_value); end
    rst = 1'b0;
  endtask

  task automatic test_write();
    logic req; logic [ARCH-1:0] addr; logic we; logic [VALB-1:0] wd, val, rdata;
    bit pok, got, held, bi; int unsigned lat; logic succ, to, err;
    logic [KEYB-1:0] key = KEYB'(5);
    logic [VALB-1:0] value = VALB'(8'hAB);
    cache_answer(UPSERT, key, value, err, rdata);
    run_txn(UPSERT, key, value, 0, 1, err, rdata, 0, 1'b0,
            req, addr, we, wd, pok, lat, got, val, succ, to, held, bi);
    n_tests++; if (addr !== {UPSERT, key}) begin n_fail++; $display("FAIL write_addr: got %h expected %h", addr, {UPSERT, key}); end
    n_tests++; if (we !== 1'b1 || wd !== value) begin n_fail++; $display("FAIL write_we_wdata: got we %b wdata %h expected we 1 wdata %h", we, wd, value); end
    n_tests++; if (!got || lat != 4) begin n_fail++; $display("FAIL write_latency: got %0d (seen %0d) expected 4", lat, got); end
    n_tests++; if (succ !== 1'b1 || to !== 1'b0 || val !== rdata) begin n_fail++; $display("FAIL write_rsp: got succ %b to %b value %h expected succ 1 to 0 value %h", succ, to, val, rdata); end
    n_tests++; if (!pok || !bi) begin n_fail++; $display("FAIL write_protocol: got ok %0d idle %0d expected 1 1", pok, bi); end
  endtask

  task automatic test_read();
    logic req; logic [ARCH-1:0] addr; logic we; logic [VALB-1:0] wd, val, rdata;
    bit pok, got, held, bi; int unsigned lat; logic succ, to, err;
    logic [KEYB-1:0] key = KEYB'(5);
    cache_answer(READ, key, rnd_val(), err, rdata);
    run_txn(READ, key, rnd_val(), 4, 0, err, rdata, 3, 1'b0,
            req, addr, we, wd, pok, lat, got, val, succ, to, held, bi);
    n_tests++; if (addr !== {READ, key} || we !== 1'b0 || wd !== '0) begin n_fail++; $display("FAIL read_request: got addr %h we %b wdata %h expected %h 0 0", addr, we, wd, {READ, key}); end
    n_tests++; if (!pok) begin n_fail++; $display("FAIL read_stall_stable: got %0d expected 1", pok); end
    n_tests++; if (!got || lat != 7) begin n_fail++; $display("FAIL read_latency: got %0d expected 7", lat); end
    n_tests++; if (val !== VALB'(8'hAB) || succ !== 1'b1) begin n_fail++; $display("FAIL read_value: got %h succ %b expected ab succ 1", val, succ); end
    n_tests++; if (!held || !bi) begin n_fail++; $display("FAIL read_hold: got held %0d idle %0d expected 1 1", held, bi); end
  endtask

  task automatic test_error();
    logic req; logic [ARCH-1:0] addr; logic we; logic [VALB-1:0] wd, val, rdata;
    bit pok, got, held, bi; int unsigned lat; logic succ, to, err;
    logic [KEYB-1:0] key = KEYB'(12'h777);
    logic [VALB-1:0] value = rnd_val() | VALB'(1);
    cache_answer(DELETE, key, value, err, rdata);
    run_txn(DELETE, key, value, 1, 2, err, rdata, 1, 1'b0,
            req, addr, we, wd, pok, lat, got, val, succ, to, held, bi);
    n_tests++; if (we !== 1'b1 || wd !== '0) begin n_fail++; $display("FAIL delete_request: got we %b wdata %h expected 1 0", we, wd); end
    n_tests++; if (!got || succ !== 1'b0 || to !== 1'b0) begin n_fail++; $display("FAIL delete_err: got succ %b to %b expected 0 0", succ, to); end
    n_tests++; if (val !== rdata) begin n_fail++; $display("FAIL delete_value: got %h expected %h", val, rdata); end
  endtask

  task automatic test_noop();
    logic req; logic [ARCH-1:0] addr; logic we; logic [VALB-1:0] wd, val;
    bit pok, got, held, bi; int unsigned lat; logic succ, to;
    run_txn(NOOP, rnd_key(), rnd_val(), 0, 0, 1'b0, '0, 2, 1'b0,
            req, addr, we, wd, pok, lat, got, val, succ, to, held, bi);
    n_tests++; if (req !== 1'b0 || !pok) begin n_fail++; $display("FAIL noop_no_req: got req %b ok %0d expected 0 1", req, pok); end
    n_tests++; if (!got || lat != 1) begin n_fail++; $display("FAIL noop_latency: got %0d expected 1", lat); end
    n_tests++; if (succ !== 1'b1 || val !== '0 || to !== 1'b0) begin n_fail++; $display("FAIL noop_rsp: got succ %b value %h to %b expected 1 0 0", succ, val, to); end
  endtask

  task automatic test_backpressure();
    logic req; logic [ARCH-1:0] addr; logic we; logic [VALB-1:0] wd, val, rdata;
    bit pok, got, held, bi; int unsigned lat; logic succ, to, err;
    logic [KEYB-1:0] key = rnd_key();
    logic [VALB-1:0] value = rnd_val();
    cache_answer(UPSERT, key, value, err, rdata);
    run_txn(UPSERT, key, value, 0, 0, err, rdata, 5, 1'b1,
            req, addr, we, wd, pok, lat, got, val, succ, to, held, bi);
    n_tests++; if (!held) begin n_fail++; $display("FAIL backpressure_hold: got %0d expected 1", held); end
    n_tests++; if (val !== rdata || !bi) begin n_fail++; $display("FAIL backpressure_value: got %h idle %0d expected %h 1", val, bi, rdata); end
  endtask

  task automatic test_reset_mid();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = READ;
    bus.cmd_key   = rnd_key();
    tick();
    bus.cmd_valid = 1'b0;
    bus.obi_gnt   = 1'b1;
    tick();
    bus.obi_gnt   = 1'b0;
    n_tests++; if (bus.obi_rready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_wait: got rready %b expected 1", bus.obi_rready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if ({bus.cmd_ready, bus.rsp_valid, bus.obi_rready, bus.obi_req} !== 4'b1000) begin n_fail++; $display("FAIL midreset_state: got %b expected 1000", {bus.cmd_ready, bus.rsp_valid, bus.obi_rready, bus.obi_req}); end
    bus.obi_rvalid = 1'b1;
    bus.obi_rdata  = rnd_val();
    tick();
    bus.obi_rvalid = 1'b0;
    tick();
    n_tests++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_no_rsp: got valid %b ready %b expected 0 1", bus.rsp_valid, bus.cmd_ready); end
  endtask

  task automatic test_timeout();
    logic req; logic [ARCH-1:0] addr; logic we; logic [VALB-1:0] wd, val, rdata;
    bit pok, got, held, bi; int unsigned lat; logic succ, to, err;
    logic [KEYB-1:0] key = rnd_key();
    int unsigned g = $urandom_range(0, 2);
    rdata = rnd_val();
    err   = 1'($urandom);
`ifdef CACHE_INIT_TIMEOUT_EN
    run_txn(READ, key, '0, g, 20, err, rdata, 1, 1'b0,
            req, addr, we, wd, pok, lat, got, val, succ, to, held, bi);
    n_tests++; if (!got || lat != 10 + g) begin n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", lat, 10 + g); end
    n_tests++; if (to !== 1'b1 || succ !== 1'b0 || val !== '0) begin n_fail++; $display("FAIL timeout_rsp: got to %b succ %b value %h expected 1 0 0", to, succ, val); end
    run_txn(READ, key, '0, g, 7, err, rdata, 0, 1'b0,
            req, addr, we, wd, pok, lat, got, val, succ, to, held, bi);
    n_tests++; if (!got || lat != 10 + g || to !== 1'b0) begin n_fail++; $display("FAIL timeout_limit_rvalid: got lat %0d to %b expected %0d 0", lat, to, 10 + g); end
    n_tests++; if (val !== rdata || succ !== !err) begin n_fail++; $display("FAIL timeout_limit_value: got %h succ %b expected %h %b", val, succ, rdata, !err); end
`else
    run_txn(READ, key, '0, g, 20, err, rdata, 1, 1'b0,
            req, addr, we, wd, pok, lat, got, val, succ, to, held, bi);
    n_tests++; if (!got || lat != 23 + g || to !== 1'b0) begin n_fail++; $display("FAIL long_wait: got lat %0d to %b expected %0d 0", lat, to, 23 + g); end
    n_tests++; if (val !== rdata || succ !== !err) begin n_fail++; $display("FAIL long_wait_value: got %h succ %b expected %h %b", val, succ, rdata, !err); end
`endif
  endtask

  task automatic test_back_to_back();
    logic req; logic [ARCH-1:0] addr; logic we; logic [VALB-1:0] wd, val, rdata, value, exp_wd, exp_val;
    bit pok, got, held, bi, spur; int unsigned lat, g, r, bp, exp_lat; logic succ, to, err, exp_we;
    logic [KEYB-1:0] key; operation_e op;
    for (int t = 0; t < 40; t++) begin
      op    = operation_e'(3'($urandom_range(0, 3)));
      key   = KEYB'($urandom_range(0, 7));
      value = rnd_val();
      g     = $urandom_range(0, 3);
      r     = $urandom_range(0, 3);
      bp    = $urandom_range(0, 2);
      spur  = 1'($urandom);
      cache_answer(op, key, value, err, rdata);
      exp_we  = (op != READ);
      exp_wd  = (op == UPSERT) ? value : '0;
      exp_val = (op == NOOP) ? '0 : rdata;
      exp_lat = (op == NOOP) ? 1 : 3 + g + r;
      run_txn(op, key, value, g, r, err, rdata, bp, spur,
              req, addr, we, wd, pok, lat, got, val, succ, to, held, bi);
      if (op != NOOP) begin
        n_tests++; if (addr !== {op, key} || we !== exp_we || wd !== exp_wd) begin n_fail++; $display("FAIL b2b_request[%0d]: got %h %b %h expected %h %b %h", t, addr, we, wd, {op, key}, exp_we, exp_wd); end
      end
      n_tests++; if (!got || lat != exp_lat) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", t, lat, exp_lat); end
      n_tests++; if (val !== exp_val || succ !== (op == NOOP ? 1'b1 : !err) || to !== 1'b0) begin n_fail++; $display("FAIL b2b_rsp[%0d]: got %h %b %b expected %h %b 0", t, val, succ, to, exp_val, (op == NOOP ? 1'b1 : !err)); end
      n_tests++; if (!pok || !held || !bi) begin n_fail++; $display("FAIL b2b_protocol[%0d]: got ok %0d held %0d idle %0d expected 1 1 1", t, pok, held, bi); end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write();
    test_read();
    test_error();
    test_noop();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
